// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: shared constants for the load/store unit.
//   SZ_*    : req_size codes, same encoding as the pipeline's data-extension decoder
//   state_t : lsu_ctrl FSM state encoding
package lsu_ctrl_pkg;
   localparam logic [2:0] SZ_W  = 3'b000;
   localparam logic [2:0] SZ_B  = 3'b001;
   localparam logic [2:0] SZ_H  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b011;
   localparam logic [2:0] SZ_HU = 3'b100;
   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: pipeline request/response and memory bus signals of the load/store unit.
//   req_*  : load/store request from the pipeline (req_ready back to it)
//   resp_* : one-cycle completion with extended load data / error flag
//   mem_*  : word-aligned memory access with byte-lane enables, held until mem_ack
//   modport slave  : the load/store unit
//   modport master : the pipeline plus memory environment
interface lsu_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_size;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   modport slave (
      input  req_valid, req_we, req_size, req_addr, req_wdata, mem_ack, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
   modport master (
      output req_valid, req_we, req_size, req_addr, req_wdata, mem_ack, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane/data alignment for the load/store unit.
//   size  : req_size code          off   : byte offset addr[1:0]
//   wdata : right-aligned store data
//   rd    : {rdata1, rdata0} read data across the two words
//   legal : size code is known     split : access crosses a word boundary
//   mask  : 8-bit lane mask over two words (low nibble = first word)
//   wd    : store data shifted to its lanes over two words
//   ld    : load data shifted down, truncated and extended
module lsu_align
   import lsu_ctrl_pkg::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [63:0] rd,
   output logic        legal,
   output logic        split,
   output logic [7:0]  mask,
   output logic [63:0] wd,
   output logic [31:0] ld
);
   logic [7:0]  base;
   logic [31:0] sh;
   always_comb begin
      base  = size == SZ_W ? 8'h0f : (size == SZ_H || size == SZ_HU) ? 8'h03 : 8'h01;
      mask  = base << off;
      split = |mask[7:4];
      legal = size <= SZ_HU;
      wd    = {32'b0, wdata} << {off, 3'b000};
      sh    = 32'(rd >> {off, 3'b000});
      ld    = size == SZ_B  ? {{24{sh[7]}}, sh[7:0]} :
              size == SZ_BU ? {24'b0, sh[7:0]} :
              size == SZ_H  ? {{16{sh[15]}}, sh[15:0]} :
              size == SZ_HU ? {16'b0, sh[15:0]} : sh;
   end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller splitting misaligned accesses into two word accesses.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : lsu_ctrl_if.slave (pipeline request/response and memory bus)
module lsu_ctrl
   import lsu_ctrl_pkg::*;
(
   input logic       clk,
   input logic       reset,
   lsu_ctrl_if.slave bus
);
   state_t      state;
   logic        we;
   logic [2:0]  size;
   logic [31:0] addr, wdata, rdata0;
   logic        idle, legal, split;
   logic [7:0]  mask;
   logic [63:0] wd;
   logic [31:0] ld;
   assign idle = state == IDLE;
   // In IDLE the aligner looks at the incoming request so the first access
   // can be registered on the accept edge; afterwards it uses the latched fields.
   lsu_align u_align (
      .size  (idle ? bus.req_size : size),
      .off   (idle ? bus.req_addr[1:0] : addr[1:0]),
      .wdata (idle ? bus.req_wdata : wdata),
      .rd    (state == ACC1 ? {bus.mem_rdata, rdata0} : {32'b0, bus.mem_rdata}),
      .legal (legal),
      .split (split),
      .mask  (mask),
      .wd    (wd),
      .ld    (ld)
   );
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         we             <= 1'b0;
         size           <= '0;
         addr           <= '0;
         wdata          <= '0;
         rdata0         <= '0;
         bus.req_ready  <= 1'b1;
         bus.resp_valid <= 1'b0;
         bus.resp_rdata <= '0;
         bus.resp_err   <= 1'b0;
         bus.mem_req    <= 1'b0;
         bus.mem_we     <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_be     <= '0;
         bus.mem_wdata  <= '0;
      end else begin
         case (state)
            IDLE: if (bus.req_valid) begin
               we            <= bus.req_we;
               size          <= bus.req_size;
               addr          <= bus.req_addr;
               wdata         <= bus.req_wdata;
               bus.req_ready <= 1'b0;
               if (legal) begin
                  state         <= ACC0;
                  bus.mem_req   <= 1'b1;
                  bus.mem_we    <= bus.req_we;
                  bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                  bus.mem_be    <= mask[3:0];
                  bus.mem_wdata <= bus.req_we ? wd[31:0] : '0;
               end else begin
                  state          <= RESP;
                  bus.resp_valid <= 1'b1;
                  bus.resp_err   <= 1'b1;
               end
            end
            ACC0, ACC1: if (bus.mem_ack) begin
               if (state == ACC0) rdata0 <= bus.mem_rdata;
               if (state == ACC0 && split) begin
                  state         <= ACC1;
                  bus.mem_addr  <= {addr[31:2], 2'b00} + 32'd4;
                  bus.mem_be    <= mask[7:4];
                  bus.mem_wdata <= we ? wd[63:32] : '0;
               end else begin
                  state          <= RESP;
                  bus.mem_req    <= 1'b0;
                  bus.mem_we     <= 1'b0;
                  bus.mem_addr   <= '0;
                  bus.mem_be     <= '0;
                  bus.mem_wdata  <= '0;
                  bus.resp_valid <= 1'b1;
                  bus.resp_rdata <= we ? '0 : ld;
               end
            end
            RESP: begin
               state          <= IDLE;
               bus.resp_valid <= 1'b0;
               bus.resp_rdata <= '0;
               bus.resp_err   <= 1'b0;
               bus.req_ready  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl.
module tb_lsu_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   lsu_ctrl_if bus ();
   lsu_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask
   // Present a request at a negedge in IDLE; returns at the negedge of cycle N+1.
   task automatic send(input logic we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_size  = size;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      tick();
      bus.req_valid = 1'b0;
   endtask
   initial begin
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_size  = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_mem_be", 32'(bus.mem_be), 32'h0);
      reset = 1'b0;
      tick();
      // Load byte, off 3; ack already high in IDLE must be ignored
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h80FFFFFF;
      send(1'b0, 3'b001, 32'h103, 32'h0);
      chk("lb_mem_req", 32'(bus.mem_req), 32'd1);
      chk("lb_mem_addr", bus.mem_addr, 32'h100);
      chk("lb_mem_be", 32'(bus.mem_be), 32'h8);
      chk("lb_ready_busy", 32'(bus.req_ready), 32'd0);
      chk("lb_no_early_resp", 32'(bus.resp_valid), 32'd0);
      tick();
      bus.mem_ack = 1'b0;
      chk("lb_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("lb_resp_rdata", bus.resp_rdata, 32'hFFFFFF80);
      chk("lb_resp_err", 32'(bus.resp_err), 32'd0);
      chk("lb_req_dropped", 32'(bus.mem_req), 32'd0);
      chk("lb_ready_resp", 32'(bus.req_ready), 32'd0);
      tick();
      chk("lb_resp_pulse", 32'(bus.resp_valid), 32'd0);
      chk("lb_rdata_clr", bus.resp_rdata, 32'h0);
      chk("lb_ready_idle", 32'(bus.req_ready), 32'd1);
      // Store half split across words
      bus.mem_ack = 1'b1;
      send(1'b1, 3'b010, 32'h203, 32'h0000BEEF);
      chk("sh_addr0", bus.mem_addr, 32'h200);
      chk("sh_be0", 32'(bus.mem_be), 32'h8);
      chk("sh_wdata0", bus.mem_wdata, 32'hEF000000);
      chk("sh_we0", 32'(bus.mem_we), 32'd1);
      tick();
      chk("sh_addr1", bus.mem_addr, 32'h204);
      chk("sh_be1", 32'(bus.mem_be), 32'h1);
      chk("sh_wdata1", bus.mem_wdata, 32'h000000BE);
      chk("sh_no_resp_n2", 32'(bus.resp_valid), 32'd0);
      tick();
      bus.mem_ack = 1'b0;
      chk("sh_resp_n3", 32'(bus.resp_valid), 32'd1);
      chk("sh_rdata0", bus.resp_rdata, 32'h0);
      chk("sh_we_clr", 32'(bus.mem_we), 32'd0);
      tick();
      // Load word unaligned, ack delayed 3 cycles in each access
      send(1'b0, 3'b000, 32'h1002, 32'h0);
      for (int i = 0; i < 3; i++) begin
         chk("lw_req_hold0", 32'(bus.mem_req), 32'd1);
         chk("lw_addr_hold0", bus.mem_addr, 32'h1000);
         chk("lw_be_hold0", 32'(bus.mem_be), 32'hC);
         tick();
      end
      bus.mem_rdata = 32'hAABBCCDD;
      bus.mem_ack   = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("lw_req_hold1", 32'(bus.mem_req), 32'd1);
         chk("lw_addr_hold1", bus.mem_addr, 32'h1004);
         chk("lw_be_hold1", 32'(bus.mem_be), 32'h3);
         tick();
      end
      bus.mem_rdata = 32'h11223344;
      bus.mem_ack   = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk("lw_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("lw_resp_rdata", bus.resp_rdata, 32'h3344AABB);
      tick();
      // Illegal size: response next cycle, no memory access
      send(1'b0, 3'b111, 32'h40, 32'h0);
      chk("ill_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("ill_resp_err", 32'(bus.resp_err), 32'd1);
      chk("ill_resp_rdata", bus.resp_rdata, 32'h0);
      chk("ill_no_mem_req", 32'(bus.mem_req), 32'd0);
      tick();
      chk("ill_err_clr", 32'(bus.resp_err), 32'd0);
      chk("ill_ready", 32'(bus.req_ready), 32'd1);
      // Load half signed, aligned
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h12348001;
      send(1'b0, 3'b010, 32'h10, 32'h0);
      chk("lh_be", 32'(bus.mem_be), 32'h3);
      tick();
      bus.mem_ack = 1'b0;
      chk("lh_resp_rdata", bus.resp_rdata, 32'hFFFF8001);
      tick();
      // Reset during ACC1 of a split load
      bus.mem_ack = 1'b1;
      send(1'b0, 3'b000, 32'h2001, 32'h0);
      tick();
      bus.mem_ack = 1'b0;
      chk("rs_in_acc1", bus.mem_addr, 32'h2004);
      #1 reset = 1'b1;
      #1;
      chk("rs_req_async", 32'(bus.mem_req), 32'd0);
      chk("rs_ready", 32'(bus.req_ready), 32'd1);
      chk("rs_be", 32'(bus.mem_be), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rs_no_resp", 32'(bus.resp_valid), 32'd0);
         chk("rs_idle_ready", 32'(bus.req_ready), 32'd1);
         tick();
      end
      // Load half-unsigned at top of memory: second word wraps to 0
      send(1'b0, 3'b100, 32'hFFFFFFFF, 32'h0);
      chk("hu_addr0", bus.mem_addr, 32'hFFFFFFFC);
      chk("hu_be0", 32'(bus.mem_be), 32'h8);
      bus.mem_rdata = 32'hFF000000;
      bus.mem_ack   = 1'b1;
      tick();
      chk("hu_addr1", bus.mem_addr, 32'h0);
      chk("hu_be1", 32'(bus.mem_be), 32'h1);
      bus.mem_rdata = 32'h00000012;
      tick();
      bus.mem_ack = 1'b0;
      chk("hu_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("hu_resp_rdata", bus.resp_rdata, 32'h000012FF);
      tick();
      $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
      $finish;
   end
endmodule
